// File: rtl/clk_div_pkg.sv
// ----------------------------------------------------------------------------
// clk_div_pkg
// Shared defaults and helpers for the clock divider bank.
//   DEF_CHANNELS  : default number of divider channels
//   DEF_DIV_W     : default divisor / counter width in bits
//   DEF_DIV_RESET : default divisor loaded into every channel at reset
//   high_len()    : number of cycles clk_o stays high in a period of length A,
//                   i.e. ceil(A/2), so odd divisors get the extra high cycle
// ----------------------------------------------------------------------------
package clk_div_pkg;

    localparam int DEF_CHANNELS  = 4;
    localparam int DEF_DIV_W     = 8;
    localparam int DEF_DIV_RESET = 8;

    // Worked in 32 bits so callers of any divisor width can share it.
    function automatic logic [31:0] high_len(input logic [31:0] div);
        return (div + 32'd1) >> 1;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// ----------------------------------------------------------------------------
// clk_div_chan
// One divider channel: counter, active divisor, shadow divisor and pending
// flag. Outputs are registered, decoded from the next-state values.
// Ports:
//   clk, rst_n   : system clock, synchronous active-low reset
//   en_i         : run enable for this channel
//   sync_i       : restart this channel at phase 0, applying any shadow
//   wr_i         : accepted divisor write targeting this channel (already
//                  range-checked by the bank)
//   wdata_i      : divisor value carried by the write
//   clk_o        : divided clock level
//   tick_o       : one-cycle pulse on the first cycle of each period
//   pending_o    : a shadow divisor is waiting to be applied
// ----------------------------------------------------------------------------
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int DIV_W     = DEF_DIV_W,
    parameter int DIV_RESET = DEF_DIV_RESET
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             sync_i,
    input  logic             wr_i,
    input  logic [DIV_W-1:0] wdata_i,
    output logic             clk_o,
    output logic             tick_o,
    output logic             pending_o
);

    localparam logic [DIV_W-1:0] DIV_INIT = DIV_W'(DIV_RESET);
    localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] act_q, act_d;
    logic [DIV_W-1:0] shd_q, shd_d;
    logic             pend_q, pend_d;
    logic             en_q, en_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             last_cnt;

    // The counter never exceeds act_q-1, so ">=" is just a safe wrap test.
    assign last_cnt = (cnt_q >= act_q - ONE);

    always_comb begin
        shd_d  = wr_i ? wdata_i : shd_q;
        pend_d = wr_i ? 1'b1 : pend_q;
        act_d  = act_q;
        cnt_d  = cnt_q;
        en_d   = en_i;

        if (sync_i) begin
            // A write landing in the sync cycle takes effect right away.
            cnt_d  = '0;
            act_d  = wr_i ? wdata_i : (pend_q ? shd_q : act_q);
            pend_d = 1'b0;
        end else if (!en_i) begin
            // Idle channel sits at phase 0; shadows need not wait for a wrap.
            cnt_d = '0;
            if (pend_q) begin
                act_d  = shd_q;
                pend_d = wr_i;
            end
        end else if (!en_q || last_cnt) begin
            // Start of a new period: either a wrap or a fresh enable.
            cnt_d = '0;
            if (pend_q) begin
                act_d  = shd_q;
                pend_d = wr_i;
            end
        end else begin
            cnt_d = cnt_q + ONE;
        end

        clk_d  = en_i && (32'(cnt_d) < high_len(32'(act_d)));
        tick_d = en_i && (cnt_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            act_q  <= DIV_INIT;
            shd_q  <= DIV_INIT;
            pend_q <= 1'b0;
            en_q   <= 1'b0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            act_q  <= act_d;
            shd_q  <= shd_d;
            pend_q <= pend_d;
            en_q   <= en_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

    assign clk_o     = clk_q;
    assign tick_o    = tick_q;
    assign pending_o = pend_q;

endmodule

// File: rtl/clk_div_bank.sv
// ----------------------------------------------------------------------------
// clk_div_bank
// Bank of CHANNELS independent clock dividers sharing one divisor write port.
// Ports:
//   clk, rst_n  : system clock, synchronous active-low reset
//   en_i        : per-channel run enable
//   sync_i      : restart all channels phase-aligned, applying shadows
//   cfg_we_i    : one-cycle divisor write strobe
//   cfg_ch_i    : target channel of the write
//   cfg_div_i   : new divisor value (must be >= 2)
//   cfg_err_o   : pulses the cycle after a rejected write
//   pending_o   : per-channel shadow divisor waiting to be applied
//   clk_o       : per-channel divided clock level (data/enable use only)
//   tick_o      : per-channel pulse at the start of each divided period
// ----------------------------------------------------------------------------
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int CHANNELS  = DEF_CHANNELS,
    parameter int DIV_W     = DEF_DIV_W,
    parameter int DIV_RESET = DEF_DIV_RESET,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] en_i,
    input  logic                sync_i,
    input  logic                cfg_we_i,
    input  logic [CH_W-1:0]     cfg_ch_i,
    input  logic [DIV_W-1:0]    cfg_div_i,
    output logic                cfg_err_o,
    output logic [CHANNELS-1:0] pending_o,
    output logic [CHANNELS-1:0] clk_o,
    output logic [CHANNELS-1:0] tick_o
);

    logic                cfg_ok;
    logic                cfg_err_q, cfg_err_d;
    logic [CHANNELS-1:0] chan_wr;

    // Channel index is checked against CHANNELS, not the port width, since
    // a non-power-of-two bank leaves encodable but nonexistent channels.
    assign cfg_ok = cfg_we_i
                  && (cfg_div_i >= DIV_W'(2))
                  && (32'(cfg_ch_i) < 32'(CHANNELS));

    always_comb begin
        cfg_err_d = cfg_we_i && !cfg_ok;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg_err_o = cfg_err_q;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        assign chan_wr[c] = cfg_ok && (32'(cfg_ch_i) == 32'(c));

        clk_div_chan #(
            .DIV_W     (DIV_W),
            .DIV_RESET (DIV_RESET)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .en_i      (en_i[c]),
            .sync_i    (sync_i),
            .wr_i      (chan_wr[c]),
            .wdata_i   (cfg_div_i),
            .clk_o     (clk_o[c]),
            .tick_o    (tick_o[c]),
            .pending_o (pending_o[c])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// ----------------------------------------------------------------------------
// tb_clk_div_bank
// Directed bench for clk_div_bank. A default 4-channel instance carries most
// scenarios; a 5-channel instance exercises writes to channel indices that
// fit the port but do not exist.
// ----------------------------------------------------------------------------
module tb_clk_div_bank;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] en_i;
    logic       sync_i;
    logic       cfg_we_i;
    logic [1:0] cfg_ch_i;
    logic [7:0] cfg_div_i;
    logic       cfg_err_o;
    logic [3:0] pending_o;
    logic [3:0] clk_o;
    logic [3:0] tick_o;

    logic [4:0] en5;
    logic       sync5;
    logic       we5;
    logic [2:0] ch5;
    logic [7:0] div5;
    logic       err5;
    logic [4:0] pend5;
    logic [4:0] clko5;
    logic [4:0] tick5;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    clk_div_bank #(.CHANNELS(4), .DIV_W(8), .DIV_RESET(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (en_i),
        .sync_i    (sync_i),
        .cfg_we_i  (cfg_we_i),
        .cfg_ch_i  (cfg_ch_i),
        .cfg_div_i (cfg_div_i),
        .cfg_err_o (cfg_err_o),
        .pending_o (pending_o),
        .clk_o     (clk_o),
        .tick_o    (tick_o)
    );

    clk_div_bank #(.CHANNELS(5), .DIV_W(8), .DIV_RESET(8)) dut5 (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (en5),
        .sync_i    (sync5),
        .cfg_we_i  (we5),
        .cfg_ch_i  (ch5),
        .cfg_div_i (div5),
        .cfg_err_o (err5),
        .pending_o (pend5),
        .clk_o     (clko5),
        .tick_o    (tick5)
    );

    // Advance one clock; outputs are read 1 time unit after the edge and new
    // inputs set here are sampled by the following edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reset both instances, then release with the given enables; on return
    // the first post-reset cycle (period phase 0) is visible.
    task automatic do_reset(input logic [3:0] en);
        rst_n     = 1'b0;
        en_i      = en;
        sync_i    = 1'b0;
        cfg_we_i  = 1'b0;
        cfg_ch_i  = 2'd0;
        cfg_div_i = 8'd0;
        en5       = 5'd0;
        sync5     = 1'b0;
        we5       = 1'b0;
        ch5       = 3'd0;
        div5      = 8'd0;
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        en_i      = 4'b1111;
        sync_i    = 1'b0;
        cfg_we_i  = 1'b0;
        cfg_ch_i  = 2'd0;
        cfg_div_i = 8'd0;
        en5       = 5'd0;
        sync5     = 1'b0;
        we5       = 1'b0;
        ch5       = 3'd0;
        div5      = 8'd0;
        cyc();
        cyc();
        total++;
        if (clk_o !== 4'b0000) begin
            bad++; $display("[TB] FAIL reset_clk got=%b want=0000", clk_o);
        end
        total++;
        if (tick_o !== 4'b0000) begin
            bad++; $display("[TB] FAIL reset_tick got=%b want=0000", tick_o);
        end
        total++;
        if (pending_o !== 4'b0000) begin
            bad++; $display("[TB] FAIL reset_pending got=%b want=0000", pending_o);
        end
        total++;
        if (cfg_err_o !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_err got=%b want=0", cfg_err_o);
        end
        rst_n = 1'b1;
        cyc();
        total++;
        if (tick_o !== 4'b1111) begin
            bad++; $display("[TB] FAIL release_tick got=%b want=1111", tick_o);
        end
        total++;
        if (clk_o !== 4'b1111) begin
            bad++; $display("[TB] FAIL release_clk got=%b want=1111", clk_o);
        end
    endtask

    task automatic test_div_reset();
        logic [3:0] exp_t, exp_c;
        do_reset(4'b0001);
        for (int k = 0; k < 17; k++) begin
            exp_t = {3'b000, (k % 8 == 0)};
            exp_c = {3'b000, (k % 8 < 4)};
            total++;
            if (tick_o !== exp_t) begin
                bad++; $display("[TB] FAIL div8_tick k=%0d got=%b want=%b", k, tick_o, exp_t);
            end
            total++;
            if (clk_o !== exp_c) begin
                bad++; $display("[TB] FAIL div8_clk k=%0d got=%b want=%b", k, clk_o, exp_c);
            end
            cyc();
        end
    endtask

    task automatic test_shadow();
        logic exp_p, exp_t, exp_c, exp_t0;
        int   j;
        do_reset(4'b0011);
        cfg_we_i  = 1'b1;
        cfg_ch_i  = 2'd1;
        cfg_div_i = 8'd6;
        cyc();
        total++;
        if (pending_o !== 4'b0010) begin
            bad++; $display("[TB] FAIL shadow_first got=%b want=0010", pending_o);
        end
        // Overwrites the 6 before it can be applied.
        cfg_div_i = 8'd3;
        cyc();
        cfg_we_i = 1'b0;
        for (int k = 2; k < 17; k++) begin
            if (k < 8) begin
                exp_p = 1'b1;
                exp_t = 1'b0;
                exp_c = (k < 4);
            end else begin
                j     = k - 8;
                exp_p = 1'b0;
                exp_t = (j % 3 == 0);
                exp_c = (j % 3 < 2);
            end
            exp_t0 = (k % 8 == 0);
            total++;
            if (pending_o[1] !== exp_p) begin
                bad++; $display("[TB] FAIL shadow_pend k=%0d got=%b want=%b", k, pending_o[1], exp_p);
            end
            total++;
            if (tick_o[1] !== exp_t) begin
                bad++; $display("[TB] FAIL shadow_tick k=%0d got=%b want=%b", k, tick_o[1], exp_t);
            end
            total++;
            if (clk_o[1] !== exp_c) begin
                bad++; $display("[TB] FAIL shadow_clk k=%0d got=%b want=%b", k, clk_o[1], exp_c);
            end
            total++;
            if (tick_o[0] !== exp_t0) begin
                bad++; $display("[TB] FAIL shadow_ch0 k=%0d got=%b want=%b", k, tick_o[0], exp_t0);
            end
            cyc();
        end
    endtask

    task automatic test_cfg_err();
        do_reset(4'b0001);
        cfg_we_i  = 1'b1;
        cfg_ch_i  = 2'd0;
        cfg_div_i = 8'd1;
        we5       = 1'b1;
        ch5       = 3'd7;
        div5      = 8'd3;
        cyc();
        total++;
        if (cfg_err_o !== 1'b1) begin
            bad++; $display("[TB] FAIL err_div1 got=%b want=1", cfg_err_o);
        end
        total++;
        if (pending_o !== 4'b0000) begin
            bad++; $display("[TB] FAIL err_div1_pend got=%b want=0000", pending_o);
        end
        total++;
        if (err5 !== 1'b1) begin
            bad++; $display("[TB] FAIL err_ch7 got=%b want=1", err5);
        end
        total++;
        if (pend5 !== 5'b00000) begin
            bad++; $display("[TB] FAIL err_ch7_pend got=%b want=00000", pend5);
        end
        cfg_ch_i  = 2'd2;
        cfg_div_i = 8'd0;
        ch5       = 3'd4;
        cyc();
        total++;
        if (cfg_err_o !== 1'b1) begin
            bad++; $display("[TB] FAIL err_div0 got=%b want=1", cfg_err_o);
        end
        total++;
        if (pending_o !== 4'b0000) begin
            bad++; $display("[TB] FAIL err_div0_pend got=%b want=0000", pending_o);
        end
        total++;
        if (err5 !== 1'b0) begin
            bad++; $display("[TB] FAIL ok_ch4_err got=%b want=0", err5);
        end
        total++;
        if (pend5 !== 5'b10000) begin
            bad++; $display("[TB] FAIL ok_ch4_pend got=%b want=10000", pend5);
        end
        cfg_we_i = 1'b0;
        we5      = 1'b0;
        cyc();
        total++;
        if (cfg_err_o !== 1'b0) begin
            bad++; $display("[TB] FAIL err_oneshot got=%b want=0", cfg_err_o);
        end
        // Divisor must still be 8: next tick at k=8.
        for (int k = 3; k < 9; k++) begin
            total++;
            if (tick_o[0] !== (k == 8)) begin
                bad++; $display("[TB] FAIL err_keepdiv k=%0d got=%b want=%b", k, tick_o[0], (k == 8));
            end
            cyc();
        end
    endtask

    task automatic test_sync();
        do_reset(4'b0000);
        cfg_we_i  = 1'b1;
        cfg_ch_i  = 2'd0;
        cfg_div_i = 8'd5;
        cyc();
        cfg_ch_i  = 2'd1;
        cfg_div_i = 8'd7;
        cyc();
        cfg_we_i = 1'b0;
        cyc();
        cyc();
        total++;
        if (pending_o !== 4'b0000) begin
            bad++; $display("[TB] FAIL idle_apply got=%b want=0000", pending_o);
        end
        total++;
        if (clk_o !== 4'b0000) begin
            bad++; $display("[TB] FAIL idle_clk got=%b want=0000", clk_o);
        end
        en_i = 4'b0001;
        repeat (3) cyc();
        en_i = 4'b0011;
        repeat (2) cyc();
        sync_i = 1'b1;
        cyc();
        sync_i = 1'b0;
        for (int j = 0; j < 15; j++) begin
            total++;
            if (tick_o[1:0] !== {(j % 7 == 0), (j % 5 == 0)}) begin
                bad++; $display("[TB] FAIL sync_tick j=%0d got=%b want=%b", j, tick_o[1:0], {(j % 7 == 0), (j % 5 == 0)});
            end
            total++;
            if (clk_o[1:0] !== {(j % 7 < 4), (j % 5 < 3)}) begin
                bad++; $display("[TB] FAIL sync_clk j=%0d got=%b want=%b", j, clk_o[1:0], {(j % 7 < 4), (j % 5 < 3)});
            end
            cyc();
        end
        // Write in the sync cycle itself is applied immediately.
        sync_i    = 1'b1;
        cfg_we_i  = 1'b1;
        cfg_ch_i  = 2'd0;
        cfg_div_i = 8'd4;
        cyc();
        sync_i   = 1'b0;
        cfg_we_i = 1'b0;
        total++;
        if (pending_o !== 4'b0000) begin
            bad++; $display("[TB] FAIL syncwr_pend got=%b want=0000", pending_o);
        end
        for (int j = 0; j < 8; j++) begin
            total++;
            if (tick_o[1:0] !== {(j % 7 == 0), (j % 4 == 0)}) begin
                bad++; $display("[TB] FAIL syncwr_tick j=%0d got=%b want=%b", j, tick_o[1:0], {(j % 7 == 0), (j % 4 == 0)});
            end
            total++;
            if (clk_o[1:0] !== {(j % 7 < 4), (j % 4 < 2)}) begin
                bad++; $display("[TB] FAIL syncwr_clk j=%0d got=%b want=%b", j, clk_o[1:0], {(j % 7 < 4), (j % 4 < 2)});
            end
            cyc();
        end
    endtask

    task automatic test_disable();
        do_reset(4'b0100);
        cyc();
        cfg_we_i  = 1'b1;
        cfg_ch_i  = 2'd2;
        cfg_div_i = 8'd4;
        cyc();
        cfg_we_i = 1'b0;
        total++;
        if (pending_o !== 4'b0100) begin
            bad++; $display("[TB] FAIL dis_pend_before got=%b want=0100", pending_o);
        end
        total++;
        if (clk_o[2] !== 1'b1) begin
            bad++; $display("[TB] FAIL dis_clk_before got=%b want=1", clk_o[2]);
        end
        en_i = 4'b0000;
        cyc();
        total++;
        if (clk_o !== 4'b0000) begin
            bad++; $display("[TB] FAIL dis_clk got=%b want=0000", clk_o);
        end
        total++;
        if (tick_o !== 4'b0000) begin
            bad++; $display("[TB] FAIL dis_tick got=%b want=0000", tick_o);
        end
        total++;
        if (pending_o !== 4'b0000) begin
            bad++; $display("[TB] FAIL dis_pend got=%b want=0000", pending_o);
        end
        en_i = 4'b0100;
        cyc();
        for (int j = 0; j < 9; j++) begin
            total++;
            if (tick_o[2] !== (j % 4 == 0)) begin
                bad++; $display("[TB] FAIL reen_tick j=%0d got=%b want=%b", j, tick_o[2], (j % 4 == 0));
            end
            total++;
            if (clk_o[2] !== (j % 4 < 2)) begin
                bad++; $display("[TB] FAIL reen_clk j=%0d got=%b want=%b", j, clk_o[2], (j % 4 < 2));
            end
            cyc();
        end
    endtask

    task automatic test_reset_pending();
        do_reset(4'b0001);
        cfg_we_i  = 1'b1;
        cfg_ch_i  = 2'd0;
        cfg_div_i = 8'd3;
        cyc();
        cfg_we_i = 1'b0;
        total++;
        if (pending_o !== 4'b0001) begin
            bad++; $display("[TB] FAIL rstp_before got=%b want=0001", pending_o);
        end
        rst_n = 1'b0;
        cyc();
        total++;
        if ({clk_o, tick_o, pending_o, cfg_err_o} !== 13'd0) begin
            bad++; $display("[TB] FAIL rstp_outputs got=%b want=0", {clk_o, tick_o, pending_o, cfg_err_o});
        end
        rst_n = 1'b1;
        cyc();
        for (int j = 0; j < 10; j++) begin
            total++;
            if (tick_o[0] !== (j % 8 == 0)) begin
                bad++; $display("[TB] FAIL rstp_tick j=%0d got=%b want=%b", j, tick_o[0], (j % 8 == 0));
            end
            total++;
            if (clk_o[0] !== (j % 8 < 4)) begin
                bad++; $display("[TB] FAIL rstp_clk j=%0d got=%b want=%b", j, clk_o[0], (j % 8 < 4));
            end
            cyc();
        end
    endtask

    task automatic test_div2();
        do_reset(4'b0000);
        cfg_we_i  = 1'b1;
        cfg_ch_i  = 2'd3;
        cfg_div_i = 8'd2;
        cyc();
        cfg_we_i = 1'b0;
        cyc();
        cyc();
        en_i = 4'b1000;
        cyc();
        for (int j = 0; j < 8; j++) begin
            total++;
            if (tick_o[3] !== (j % 2 == 0)) begin
                bad++; $display("[TB] FAIL div2_tick j=%0d got=%b want=%b", j, tick_o[3], (j % 2 == 0));
            end
            total++;
            if (clk_o[3] !== (j % 2 == 0)) begin
                bad++; $display("[TB] FAIL div2_clk j=%0d got=%b want=%b", j, clk_o[3], (j % 2 == 0));
            end
            cyc();
        end
    endtask

    initial begin
        $display("[TB] clk_div_bank directed tests starting");
        test_reset();
        test_div_reset();
        test_shadow();
        test_cfg_err();
        test_sync();
        test_disable();
        test_reset_pending();
        test_div2();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
